// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the multi_timer block.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } timer_mode_e;

    localparam int unsigned c_PERIOD_50MHZ = 32'd50000000;
    localparam int unsigned c_PERIOD_SIM   = 32'd5;

    // Width of a channel selector; a single channel still gets one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer_if
// Description : Control/status bundle of the multi_timer block.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_timer_if
    import timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) ();

    localparam int c_CW = chan_width(CHANNELS);

    logic                wr_en;
    logic [c_CW-1:0]     wr_chan;
    logic [WIDTH-1:0]    wr_period;
    logic                wr_oneshot;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] running;

    modport master (
        output wr_en, wr_chan, wr_period, wr_oneshot, start, stop,
        input  tick, running
    );

    modport slave (
        input  wr_en, wr_chan, wr_period, wr_oneshot, start, stop,
        output tick, running
    );

endinterface

`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One timer channel: counter, active/pending period and mode.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int          WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = c_PERIOD_50MHZ,
    parameter bit          AUTO_START     = 1'b1
) (
    input  wire logic             clock,
    input  wire logic             rst,
    input  wire logic             step,
    input  wire logic             wr,
    input  wire logic [WIDTH-1:0] wr_period,
    input  wire logic             wr_oneshot,
    input  wire logic             start,
    input  wire logic             stop,
    output logic                  tick,
    output logic                  running
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_pend_period;
    logic             r_pend_valid;
    timer_mode_e      r_mode;
    logic             r_running;
    logic             r_tick;

    logic [WIDTH-1:0] w_last;
    logic             w_wrap;

    // Period 0 behaves as period 1: the last count value is 0 either way.
    assign w_last = (r_period == '0) ? '0 : (r_period - WIDTH'(1));
    assign w_wrap = r_running && step && (r_cnt == w_last);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period      <= WIDTH'(DEFAULT_PERIOD);
            r_pend_period <= '0;
            r_pend_valid  <= 1'b0;
            r_mode        <= MODE_PERIODIC;
            r_running     <= AUTO_START;
            r_tick        <= 1'b0;
        end else begin
            r_tick <= w_wrap && !stop && !start;

            if (wr) begin
                r_mode <= timer_mode_e'(wr_oneshot);
                if (r_running) begin
                    r_pend_period <= wr_period;
                    r_pend_valid  <= 1'b1;
                end else begin
                    r_period     <= wr_period;
                    r_pend_valid <= 1'b0;
                end
            end

            // Later assignments below override the write path where a
            // start or wrap makes the new period active immediately.
            if (stop) begin
                r_running <= 1'b0;
            end else if (start) begin
                r_running <= 1'b1;
                r_cnt     <= '0;
                if (wr) begin
                    r_period     <= wr_period;
                    r_pend_valid <= 1'b0;
                end else if (r_pend_valid) begin
                    r_period     <= r_pend_period;
                    r_pend_valid <= 1'b0;
                end
            end else if (w_wrap) begin
                r_cnt <= '0;
                if (wr) begin
                    r_period     <= wr_period;
                    r_pend_valid <= 1'b0;
                end else if (r_pend_valid) begin
                    r_period     <= r_pend_period;
                    r_pend_valid <= 1'b0;
                end
                if (r_mode == MODE_ONESHOT) begin
                    r_running <= 1'b0;
                end
            end else if (r_running && step) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign tick    = r_tick;
    assign running = r_running;

endmodule

`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : Multi-channel programmable tick generator. Optional shared
//               prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_timer
    import timer_pkg::*;
#(
    parameter int          CHANNELS       = 4,
    parameter int          WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = c_PERIOD_50MHZ,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned PRESCALE       = 1
) (
    input  wire logic     clock,
    input  wire logic     rst,
    multi_timer_if.slave  bus
);

    logic                w_step;
    logic [CHANNELS-1:0] w_wr;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_running;

`ifdef MULTI_TIMER_PRESCALE_EN
    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [c_PW-1:0] r_pre;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_pre <= '0;
        end else if (r_pre == c_PW'(PRESCALE - 1)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PW'(1);
        end
    end

    assign w_step = (r_pre == c_PW'(PRESCALE - 1));
`else
    logic w_unused_prescale;

    assign w_step            = 1'b1;
    assign w_unused_prescale = (PRESCALE != 0);
`endif

    // Out-of-range channel numbers match no decode and are dropped.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            assign w_wr[i] = bus.wr_en && (int'(bus.wr_chan) == i);

            timer_channel #(
                .WIDTH          (WIDTH),
                .DEFAULT_PERIOD (DEFAULT_PERIOD),
                .AUTO_START     (AUTO_START)
            ) u_chan (
                .clock      (clock),
                .rst        (rst),
                .step       (w_step),
                .wr         (w_wr[i]),
                .wr_period  (bus.wr_period),
                .wr_oneshot (bus.wr_oneshot),
                .start      (bus.start[i]),
                .stop       (bus.stop[i]),
                .tick       (w_tick[i]),
                .running    (w_running[i])
            );
        end
    endgenerate

    assign bus.tick    = w_tick;
    assign bus.running = w_running;

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_timer
// Description : Directed self-checking bench for multi_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_timer;
    import timer_pkg::*;

    localparam int c_CH = 6;
    localparam int c_W  = 16;

    logic clock = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clock = ~clock;

    multi_timer_if #(.CHANNELS(c_CH), .WIDTH(c_W)) bus ();

    multi_timer #(
        .CHANNELS       (c_CH),
        .WIDTH          (c_W),
        .DEFAULT_PERIOD (c_PERIOD_SIM),
        .AUTO_START     (1'b1),
        .PRESCALE       (4)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic write(input int ch, input int per, input logic os);
        bus.wr_en      = 1'b1;
        bus.wr_chan    = 3'(ch);
        bus.wr_period  = c_W'(per);
        bus.wr_oneshot = os;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_tick0(input string tag, output int at);
        int found = 0;
        at = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            step();
            if (bus.tick[0]) begin
                found = 1;
                at    = cyc;
            end
        end
        check(tag, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   t0, t1, t2;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_chan    = '0;
        bus.wr_period  = '0;
        bus.wr_oneshot = 1'b0;
        bus.start      = '0;
        bus.stop       = '0;
        do_reset();
        check("reset_running", bus.running, 6'h3F);
        check("reset_tick", bus.tick, 6'h00);

`ifdef MULTI_TIMER_PRESCALE_EN
        bus.stop = 6'h3F;
        step();
        bus.stop = '0;
        write(0, 2, 1'b0);
        step();
        bus.wr_en = 1'b0;
        bus.start = 6'h01;
        step();
        bus.start = '0;
        wait_tick0("pre_first_tick", t0);
        step();
        check("pre_tick_width", bus.tick[0], 1'b0);
        wait_tick0("pre_second_tick", t1);
        check("pre_interval1", t1 - t0, 8);
        step();
        check("pre_tick_width2", bus.tick[0], 1'b0);
        wait_tick0("pre_third_tick", t2);
        check("pre_interval2", t2 - t1, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("pre_rst_tick", bus.tick, 6'h00);
        check("pre_rst_running", bus.running, 6'h3F);
`else
        // Auto-started channels at the default period of 5.
        for (int e = 1; e <= 15; e++) begin
            step();
            check($sformatf("auto_tick_e%0d", e), bus.tick, (e % 5 == 0) ? 6'h3F : 6'h00);
        end
        bus.stop = 6'h3F;
        step();
        bus.stop = '0;
        check("stop_all", bus.running, 6'h00);

        // One-shot on ch1, period 3.
        write(1, 3, 1'b1);
        step();
        bus.wr_en = 1'b0;
        bus.start = 6'h02;
        step();
        bus.start = '0;
        check("os_start_running", bus.running, 6'h02);
        for (int j = 1; j <= 5; j++) begin
            step();
            check($sformatf("os_tick_%0d", j), bus.tick[1], (j == 3) ? 1'b1 : 1'b0);
            check($sformatf("os_run_%0d", j), bus.running[1], (j < 3) ? 1'b1 : 1'b0);
        end

        // Pending period on running ch0: 3 then overwritten by 2.
        bus.start = 6'h01;
        step();
        bus.start = '0;
        for (int j = 1; j <= 9; j++) begin
            step();
            if (j == 1) write(0, 3, 1'b0);
            else if (j == 2) write(0, 2, 1'b0);
            else bus.wr_en = 1'b0;
            check($sformatf("pend_tick_%0d", j), bus.tick[0], (j == 5 || j == 7 || j == 9) ? 1'b1 : 1'b0);
        end
        bus.stop = 6'h01;
        step();
        bus.stop = '0;

        // Start and stop together on ch2: stop wins.
        bus.start = 6'h04;
        bus.stop  = 6'h04;
        step();
        bus.start = '0;
        bus.stop  = '0;
        check("ss_running", bus.running[2], 1'b0);
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            seen = seen | bus.tick[2];
        end
        check("ss_no_tick", seen, 1'b0);

        // Stop landing on the wrap edge of ch3 suppresses the tick.
        bus.start = 6'h08;
        step();
        bus.start = '0;
        for (int j = 1; j <= 4; j++) step();
        bus.stop = 6'h08;
        step();
        bus.stop = '0;
        check("stopwrap_tick", bus.tick[3], 1'b0);
        check("stopwrap_running", bus.running[3], 1'b0);

        // Period 0 on ch4 ticks every cycle.
        write(4, 0, 1'b0);
        step();
        bus.wr_en = 1'b0;
        bus.start = 6'h10;
        step();
        bus.start = '0;
        check("p0_first", bus.tick[4], 1'b0);
        for (int j = 1; j <= 4; j++) begin
            step();
            check($sformatf("p0_tick_%0d", j), bus.tick[4], 1'b1);
        end

        // Reset while ch4 is ticking.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_tick", bus.tick, 6'h00);
        check("midrst_running", bus.running, 6'h3F);

        // Writes to channels 7 and 6 do not exist and must change nothing.
        write(7, 1, 1'b1);
        step();
        bus.wr_chan = 3'd6;
        step();
        bus.wr_en = 1'b0;
        step();
        step();
        step();
        check("oor_tick_e5", bus.tick, 6'h3F);
        check("oor_running_e5", bus.running, 6'h3F);
        step();
        check("oor_tick_e6", bus.tick, 6'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
